// File: rtl/spi_cs_pkg.sv
// Shared constants, state type and select-code mapping
// for the four-slave SPI master.
package spi_cs_pkg;

  localparam logic [3:0] CS_DEV0 = 4'b0011;
  localparam logic [3:0] CS_DEV1 = 4'b1101;
  localparam logic [3:0] CS_DEV2 = 4'b1011;
  localparam logic [3:0] CS_DEV3 = 4'b0111;
  localparam logic [3:0] CS_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_e;

  function automatic logic [3:0] dev_to_code(
    input logic [1:0] dev
  );
    logic [3:0] c;
    unique case (dev)
      2'd0: c = CS_DEV0;
      2'd1: c = CS_DEV1;
      2'd2: c = CS_DEV2;
      2'd3: c = CS_DEV3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick source: pulses every CLK_DIV cycles
// while enabled, restarts from zero on clear.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_cs4.sv
// Mode-0 MSB-first SPI master driving one of four slaves
// through the 4-bit chip-select code bus.
module spi_master_cs4
  import spi_cs_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        dev_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  output logic [3:0]        cs_code,
  input  logic              miso
);

  localparam int HW = $clog2(2 * DATA_W + 1);
  localparam logic [HW-1:0] HALF_END  = HW'(2 * DATA_W);
  localparam logic [HW-1:0] LAST_FALL = HW'(2 * DATA_W - 1);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] rxsh_q;
  logic [DATA_W-1:0] tx_q;
  logic              sclk_q;
  logic              mosi_q;
  logic [3:0]        cs_q;
  logic [HW-1:0]     hcnt_q;

  logic tick;
  logic accept;

  assign accept = (state_q == ST_IDLE) && start;

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state_q != ST_IDLE),
    .tick (tick)
  );

  // hcnt_q counts sclk half-periods; the one past the
  // last falling edge is the trailing low half before HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= '0;
      rxsh_q  <= '0;
      tx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= CS_IDLE;
      hcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SETUP;
            busy_q  <= 1'b1;
            cs_q    <= dev_to_code(dev_sel);
            tx_q    <= tx_data;
            mosi_q  <= tx_data[DATA_W-1];
            rxsh_q  <= '0;
            hcnt_q  <= '0;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state_q <= ST_SHIFT;
            sclk_q  <= 1'b1;
            rxsh_q  <= {rxsh_q[DATA_W-2:0], miso};
            hcnt_q  <= HW'(1);
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (hcnt_q == HALF_END) begin
              state_q <= ST_HOLD;
            end else begin
              hcnt_q <= hcnt_q + HW'(1);
              sclk_q <= ~sclk_q;
              if (sclk_q) begin
                if (hcnt_q != LAST_FALL) begin
                  tx_q   <= tx_q << 1;
                  mosi_q <= tx_q[DATA_W-2];
                end
              end else begin
                rxsh_q <= {rxsh_q[DATA_W-2:0], miso};
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rx_q    <= rxsh_q;
            cs_q    <= CS_IDLE;
            mosi_q  <= 1'b0;
            hcnt_q  <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_code = cs_q;

endmodule

// File: tb/tb_spi_master_cs4.sv
// Scoreboard bench for spi_master_cs4 with a behavioural
// slave and decoder model.
module tb_spi_master_cs4;

  localparam int DW = 8;
  localparam int H  = 2;
  localparam int BUSY_LEN = H * (2 * DW + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    dev_sel = '0;
  logic [DW-1:0] tx_data = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] rx_data;
  logic          sclk;
  logic          mosi;
  logic [3:0]    cs_code;
  logic          miso = 1'b1;

  always #5 clk = ~clk;

  spi_master_cs4 #(
    .DATA_W  (DW),
    .CLK_DIV (H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dev_sel (dev_sel),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_code (cs_code),
    .miso    (miso)
  );

  typedef struct packed {
    logic [1:0]    dev;
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_issued = 0;
  int n_aborted = 0;

  logic [3:0] code_tab [4] =
    '{4'b0011, 4'b1101, 4'b1011, 4'b0111};

  logic [DW-1:0] slave_word = '0;
  bit            slave_en = 1'b0;

  int            rises = 0;
  int            bcnt = 0;
  logic [DW-1:0] mosi_w = '0;
  bit            cs_bad = 1'b0;
  logic          sclk_prev = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Monitor + slave: samples mid-cycle, checks on done,
  // then presents the next slave bit for the coming rise.
  always @(negedge clk) begin
    if (rst) begin
      rises  = 0;
      bcnt   = 0;
      mosi_w = '0;
      cs_bad = 1'b0;
    end else begin
      if (sclk && !sclk_prev) begin
        rises++;
        mosi_w = {mosi_w[DW-2:0], mosi};
      end
      if (busy) begin
        bcnt++;
        if (q.size() == 0) cs_bad = 1'b1;
        else if (cs_code !== code_tab[q[0].dev])
          cs_bad = 1'b1;
      end
      if (done) begin
        n_done++;
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(mon_e.rx));
          chk("mosi_bits", 32'(mosi_w), 32'(mon_e.tx));
          chk("rise_count", 32'(rises), 32'(DW));
          chk("busy_len", 32'(bcnt), 32'(BUSY_LEN));
          chk("cs_during_busy", 32'(cs_bad), 32'd0);
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("cs_at_done", 32'(cs_code), 32'hF);
        end
        rises  = 0;
        bcnt   = 0;
        mosi_w = '0;
        cs_bad = 1'b0;
      end
    end
    sclk_prev = sclk;
    if (cs_code == 4'hF || !slave_en || rises >= DW)
      miso = 1'b1;
    else
      miso = slave_word[DW-1-rises];
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] d,
                       input logic [DW-1:0] tx,
                       input logic [DW-1:0] sw,
                       input bit en);
    int t;
    t = 0;
    while (busy && t < 2000) begin
      step();
      t++;
    end
    if (t >= 2000) tmo("issue_wait");
    start      = 1'b1;
    dev_sel    = d;
    tx_data    = tx;
    slave_word = sw;
    slave_en   = en;
    q.push_back('{dev: d, tx: tx,
                  rx: en ? sw : {DW{1'b1}}});
    n_issued++;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 5000) begin
      step();
      t++;
    end
    if (t >= 5000) tmo("wait_idle");
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs"}, 32'(cs_code), 32'hF);
    chk({tag, "_sclk"}, 32'(sclk), 32'd0);
    chk({tag, "_mosi"}, 32'(mosi), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rx"}, 32'(rx_data), 32'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    issue(2'd2, 8'hA5, 8'h3C, 1'b1);
    wait_idle();

    for (int d = 0; d < 4; d++) begin
      issue(2'(d), 8'($urandom), 8'($urandom), 1'b0);
      wait_idle();
      repeat (2) step();
    end

    issue(2'd0, 8'($urandom), 8'($urandom), 1'b1);
    t = 0;
    while (!done && t < 500) begin
      step();
      t++;
    end
    if (t >= 500) tmo("b2b_done");
    chk("b2b_gap_cs", 32'(cs_code), 32'hF);
    issue(2'd1, 8'h01, 8'($urandom), 1'b1);
    chk("b2b_second_cs", 32'(cs_code), 32'hD);
    wait_idle();

    issue(2'd3, 8'h96, 8'h5A, 1'b1);
    repeat (20) begin
      step();
      start   = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
      dev_sel = 2'($urandom);
    end
    start = 1'b0;
    wait_idle();
    repeat (10) step();

    issue(2'd1, 8'($urandom), 8'($urandom), 1'b1);
    t = 0;
    while (rises < 4 && t < 500) begin
      step();
      t++;
    end
    if (t >= 500) tmo("mid_rise_wait");
    rst = 1'b1;
    step();
    chk_reset("midrst");
    q.delete();
    n_aborted++;
    rst = 1'b0;
    repeat (3) step();
    issue(2'd2, 8'hC3, 8'h81, 1'b1);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      issue(2'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (10) step();

    chk("done_count", 32'(n_done),
        32'(n_issued - n_aborted));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
